// File: rtl/drive_cmd_arbiter_if.sv
// -----------------------------------------------------------------------------
// drive_cmd_arbiter_if
//   Valid/ready command channel between the drive command arbiter and the
//   UART/JSON command sender.
//
//   Signals:
//     cmd_out   [2:0]  command code presented to the sender
//     cmd_valid        cmd_out is valid
//     cmd_ready        sender accepts cmd_out this cycle
//
//   Modports:
//     master  arbiter side  (drives cmd_out/cmd_valid, samples cmd_ready)
//     slave   sender side   (samples cmd_out/cmd_valid, drives cmd_ready)
// -----------------------------------------------------------------------------
interface drive_cmd_arbiter_if;
  logic [2:0] cmd_out;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_out, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_out, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// drive_cmd_arbiter
//   Chooses between the IR command decoder (manual mode) and the autonomous
//   navigation source (auto mode), keeps a single latest-wins pending command
//   and issues it to the command sender over a valid/ready handshake, with a
//   forced idle gap after every accepted command. Inserts safety STOPs on a
//   mode toggle and on a manual-mode inactivity timeout, and keeps a
//   saturating speed level driven by accepted FAST/SLOW commands.
//
//   Parameters:
//     MIN_GAP    idle cycles forced after each accepted command (0 = none)
//     TIMEOUT    manual-mode cycles without an IR command before a STOP
//     SPEED_W    width of speed_level
//     MAX_SPEED  saturation ceiling of speed_level (< 2**SPEED_W)
//
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     ir_cmd[2:0]       IR command code (STOP=0 LEFT=1 RIGHT=2 FAST=3 SLOW=4)
//     ir_cmd_valid      one-cycle strobe qualifying ir_cmd
//     ir_toggle         one-cycle strobe, flips manual/auto mode
//     auto_cmd[2:0]     autonomous command code, same encoding
//     auto_cmd_valid    one-cycle strobe qualifying auto_cmd
//     estop             level emergency stop (only with DRIVE_ARB_ESTOP_EN)
//     cmd_bus           valid/ready command channel (master side)
//     speed_level       current speed setting
//     mode_auto         0 = manual, 1 = auto
//     busy              FSM not idle, or a command is pending
//
//   Build option:
//     DRIVE_ARB_ESTOP_EN  adds the estop input; while high, pending is forced
//                         to STOP, source strobes and toggles are ignored and
//                         speed_level is held at 0.
// -----------------------------------------------------------------------------
module drive_cmd_arbiter #(
  parameter int MIN_GAP   = 4,
  parameter int TIMEOUT   = 50_000_000,
  parameter int SPEED_W   = 3,
  parameter int MAX_SPEED = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             ir_cmd,
  input  logic                   ir_cmd_valid,
  input  logic                   ir_toggle,
  input  logic [2:0]             auto_cmd,
  input  logic                   auto_cmd_valid,
`ifdef DRIVE_ARB_ESTOP_EN
  input  logic                   estop,
`endif
  drive_cmd_arbiter_if.master    cmd_bus,
  output logic [SPEED_W-1:0]     speed_level,
  output logic                   mode_auto,
  output logic                   busy
);

  localparam logic [2:0] CMD_STOP = 3'd0;
  localparam logic [2:0] CMD_FAST = 3'd3;
  localparam logic [2:0] CMD_SLOW = 3'd4;

  localparam int                 WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]    WD_FIRE   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]    WD_SAT    = WD_W'(TIMEOUT);
  localparam int                 GAP_W     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLDOFF
  } state_t;

  state_t            state, state_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic [2:0]        cmd_q;
  logic [2:0]        last_cmd;
  logic [2:0]        pend_cmd;
  logic              pend_valid;

  logic              estop_act;
  logic              sel_strobe;
  logic [2:0]        sel_cmd;
  logic              wd_fire;
  logic              wd_clr;
  logic              pend_wr;
  logic [2:0]        pend_wr_cmd;
  logic              load;
  logic              accept;

`ifdef DRIVE_ARB_ESTOP_EN
  assign estop_act = estop;
`else
  assign estop_act = 1'b0;
`endif

  // Unknown codes 5..7 are mapped to STOP so a corrupted code can never
  // become a motion command.
  function automatic logic [2:0] sanitize(input logic [2:0] code);
    return (code > 3'd4) ? CMD_STOP : code;
  endfunction

  assign cmd_bus.cmd_out   = cmd_q;
  assign cmd_bus.cmd_valid = (state == S_ISSUE);
  assign accept            = (state == S_ISSUE) && cmd_bus.cmd_ready;
  assign busy              = (state != S_IDLE) || pend_valid;

  // Only the source matching the current mode is listened to.
  assign sel_strobe = mode_auto ? auto_cmd_valid : ir_cmd_valid;
  assign sel_cmd    = mode_auto ? auto_cmd : ir_cmd;

  // The watchdog STOP is suppressed when the robot is already stopped or about
  // to be; an empty pending register counts as "not STOP".
  assign wd_fire = !mode_auto && (wd_cnt == WD_FIRE) && (last_cmd != CMD_STOP)
                   && !(pend_valid && (pend_cmd == CMD_STOP));

  assign wd_clr  = mode_auto || (!estop_act && (ir_cmd_valid || ir_toggle));

  // Pending-register write selection, highest priority first. A toggle in the
  // same cycle as a source strobe wins, so the strobe is dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pend_wr     = 1'b0;
    pend_wr_cmd = CMD_STOP;
    if (estop_act) begin
      pend_wr = 1'b1;
    end else if (ir_toggle) begin
      pend_wr = 1'b1;
    end else if (wd_fire) begin
      pend_wr = 1'b1;
    end else if (sel_strobe) begin
      pend_wr     = 1'b1;
      pend_wr_cmd = sanitize(sel_cmd);
    end
  end

  // Issue FSM: next state, holdoff counter and pending-load decision.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    load      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pend_valid) begin
          load      = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_bus.cmd_ready) begin
          state_nxt = (MIN_GAP > 0) ? S_HOLDOFF : S_IDLE;
          gap_nxt   = '0;
        end
      end
      S_HOLDOFF: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      cmd_q       <= CMD_STOP;
      last_cmd    <= CMD_STOP;
      pend_cmd    <= CMD_STOP;
      pend_valid  <= 1'b0;
      speed_level <= '0;
      mode_auto   <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;

      if (load) begin
        cmd_q <= pend_cmd;
      end

      // A write in the same cycle as a load lands in the just-emptied
      // register, so a command arriving at that moment is kept.
      if (pend_wr) begin
        pend_valid <= 1'b1;
        pend_cmd   <= pend_wr_cmd;
      end else if (load) begin
        pend_valid <= 1'b0;
      end

      if (ir_toggle && !estop_act) begin
        mode_auto <= !mode_auto;
      end

      if (accept) begin
        last_cmd <= cmd_q;
      end

      if (estop_act) begin
        speed_level <= '0;
      end else if (accept && (cmd_q == CMD_FAST) && (speed_level != SPEED_MAX)) begin
        speed_level <= speed_level + 1'b1;
      end else if (accept && (cmd_q == CMD_SLOW) && (speed_level != '0)) begin
        speed_level <= speed_level - 1'b1;
      end

      // Saturating at TIMEOUT (one past the fire value) gives exactly one
      // STOP per quiet period.
      if (wd_clr) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_SAT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drive_cmd_arbiter
//   Directed bench for drive_cmd_arbiter. A cycle-level behavioural model
//   (integers, -1 for an empty pending slot, a holdoff countdown) predicts the
//   outputs after every edge; a compare process checks the DUT against it.
//   Directed sequences add hand-computed literal checks on latency, gap,
//   latest-wins, saturation, watchdog and mode toggling.
// -----------------------------------------------------------------------------
module tb_drive_cmd_arbiter;
  localparam int MIN_GAP   = 4;
  localparam int TIMEOUT   = 100;
  localparam int SPEED_W   = 3;
  localparam int MAX_SPEED = 7;

  localparam logic [2:0] STOP = 3'd0, LEFT = 3'd1, RIGHT = 3'd2, FAST = 3'd3, SLOW = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] ir_cmd = '0, auto_cmd = '0;
  logic ir_cmd_valid = 1'b0, ir_toggle = 1'b0, auto_cmd_valid = 1'b0;
  logic estop = 1'b0;
  logic cmd_ready = 1'b0;
  logic [SPEED_W-1:0] speed_level;
  logic mode_auto, busy;

  drive_cmd_arbiter_if bus ();
  assign bus.cmd_ready = cmd_ready;

  drive_cmd_arbiter #(
    .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT), .SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ir_cmd(ir_cmd),
    .ir_cmd_valid(ir_cmd_valid),
    .ir_toggle(ir_toggle),
    .auto_cmd(auto_cmd),
    .auto_cmd_valid(auto_cmd_valid),
`ifdef DRIVE_ARB_ESTOP_EN
    .estop(estop),
`endif
    .cmd_bus(bus),
    .speed_level(speed_level),
    .mode_auto(mode_auto),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode, m_pend, m_valid, m_out, m_speed, m_last, m_wd, m_gap_left;

  task automatic model_step();
    int w;
    bit fire, sel, acc, idle;
    if (!rst_n) begin
      m_mode = 0; m_pend = -1; m_valid = 0; m_out = 0;
      m_speed = 0; m_last = 0; m_wd = 0; m_gap_left = 0;
      return;
    end
    idle = (m_valid == 0) && (m_gap_left == 0);
    acc  = (m_valid != 0) && cmd_ready;
    sel  = (m_mode != 0) ? auto_cmd_valid : ir_cmd_valid;
    fire = (m_mode == 0) && (m_wd == TIMEOUT - 1) && (m_last != 0) && (m_pend != 0);
    w = -1;
    if (estop)          w = 0;
    else if (ir_toggle) w = 0;
    else if (fire)      w = 0;
    else if (sel) begin
      w = (m_mode != 0) ? int'(auto_cmd) : int'(ir_cmd);
      if (w > 4) w = 0;
    end
    if ((m_mode != 0) || (!estop && (ir_cmd_valid || ir_toggle))) m_wd = 0;
    else if (m_wd < TIMEOUT) m_wd++;
    if (!estop && ir_toggle) m_mode = 1 - m_mode;
    if (acc) begin
      m_last = m_out;
      if (m_out == 3 && m_speed < MAX_SPEED) m_speed++;
      if (m_out == 4 && m_speed > 0) m_speed--;
      m_valid = 0;
      m_gap_left = MIN_GAP;
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end
    if (estop) m_speed = 0;
    if (idle && m_pend >= 0) begin
      m_valid = 1; m_out = m_pend; m_pend = -1;
    end
    if (w >= 0) m_pend = w;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      check("cmp_valid", bus.cmd_valid, m_valid);
      if (m_valid != 0) check("cmp_cmd_out", bus.cmd_out, m_out);
      check("cmp_speed", speed_level, m_speed);
      check("cmp_mode", mode_auto, m_mode);
      check("cmp_busy", busy, (m_valid != 0) || (m_gap_left != 0) || (m_pend >= 0));
    end
  end

  // ---------------- driver ----------------
  bit rst_want = 1'b0, rdy_want = 1'b0, est_want = 1'b0;
  int ncyc = 0;
  logic [2:0] acc_q[$];

  // One clock cycle of stimulus; logs every command the sender will accept.
  task automatic cyc(input bit iv = 1'b0, input logic [2:0] ic = '0, input bit tg = 1'b0,
                     input bit av = 1'b0, input logic [2:0] ac = '0);
    @(negedge clk);
    rst_n = rst_want; cmd_ready = rdy_want; estop = est_want;
    ir_cmd_valid = iv; ir_cmd = ic; ir_toggle = tg;
    auto_cmd_valid = av; auto_cmd = ac;
    #1;
    if (bus.cmd_valid && cmd_ready) acc_q.push_back(bus.cmd_out);
    ncyc++;
  endtask

  task automatic wait_idle(input int max_c);
    int n = 0;
    cyc();
    while (busy && n < max_c) begin
      cyc();
      n++;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  initial begin
    int n, s;
    // Reset
    rst_want = 1'b0;
    repeat (3) cyc();
    rst_want = 1'b1;
    cyc();
    check("rst_valid", bus.cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_speed", speed_level, 0);
    check("rst_mode", mode_auto, 1'b0);
    check("rst_cmd_out", bus.cmd_out, 0);

    // Latency and minimum gap
    rdy_want = 1'b1;
    cyc(1'b1, LEFT);
    cyc();
    check("lat_k1_valid", bus.cmd_valid, 1'b0);
    cyc(1'b1, RIGHT);
    check("lat_k2_valid", bus.cmd_valid, 1'b1);
    check("lat_k2_cmd", bus.cmd_out, LEFT);
    n = 0;
    do begin cyc(); n++; end while (!bus.cmd_valid && n < 20);
    check("gap_cycles", n, MIN_GAP + 2);
    check("gap_cmd", bus.cmd_out, RIGHT);
    wait_idle(40);

    // Latest wins while a STOP is held in ISSUE
    rdy_want = 1'b0;
    acc_q.delete();
    cyc(1'b1, STOP);
    cyc();
    cyc();
    check("hold_valid", bus.cmd_valid, 1'b1);
    cyc(1'b1, LEFT);
    cyc(1'b1, RIGHT);
    cyc(1'b1, FAST);
    rdy_want = 1'b1;
    wait_idle(40);
    check("lw_count", acc_q.size(), 2);
    check("lw_first", acc_q[0], STOP);
    check("lw_second", acc_q[1], FAST);
    check("lw_speed", speed_level, 1);

    // Speed saturation
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, FAST);
      wait_idle(40);
      if (i == 5) check("sat_after6", speed_level, 7);
    end
    check("sat_top", speed_level, MAX_SPEED);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, SLOW);
      wait_idle(40);
      if (i == 6) check("sat_after7slow", speed_level, 0);
    end
    check("sat_bottom", speed_level, 0);

    // Watchdog: one STOP exactly 102 cycles after the last IR strobe
    acc_q.delete();
    cyc(1'b1, LEFT);
    s = ncyc;
    while (acc_q.size() < 2 && ncyc - s < 200) cyc();
    check("wd_delay", ncyc - s, TIMEOUT + 2);
    check("wd_first", acc_q[0], LEFT);
    check("wd_stop", acc_q[1], STOP);
    repeat (150) cyc();
    check("wd_once", acc_q.size(), 2);
    acc_q.delete();
    cyc(1'b1, STOP);
    repeat (150) cyc();
    check("wd_after_stop", acc_q.size(), 1);

    // Mode toggle with a coincident IR strobe
    acc_q.delete();
    cyc(1'b1, LEFT, 1'b1);
    wait_idle(40);
    check("tog_mode", mode_auto, 1'b1);
    check("tog_count", acc_q.size(), 1);
    check("tog_stop", acc_q[0], STOP);
    cyc(1'b1, RIGHT);
    cyc();
    check("tog_ir_ignored", busy, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, RIGHT);
    wait_idle(40);
    check("auto_right", acc_q[acc_q.size()-1], RIGHT);
    cyc(1'b0, '0, 1'b0, 1'b1, 3'd6);
    wait_idle(40);
    check("auto_code6", acc_q[acc_q.size()-1], STOP);
    check("auto_count", acc_q.size(), 3);
    cyc(1'b0, '0, 1'b1);
    wait_idle(40);
    check("tog_back", mode_auto, 1'b0);

    // Reset in the middle of a handshake
    rdy_want = 1'b0;
    cyc(1'b1, RIGHT);
    cyc();
    cyc(1'b1, LEFT);
    check("mid_valid", bus.cmd_valid, 1'b1);
    acc_q.delete();
    rst_want = 1'b0;
    cyc();
    rst_want = 1'b1;
    rdy_want = 1'b1;
    cyc();
    check("mid_rst_valid", bus.cmd_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (10) cyc();
    check("mid_no_replay", acc_q.size(), 0);

`ifdef DRIVE_ARB_ESTOP_EN
    // Emergency stop during holdoff
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, FAST);
      wait_idle(40);
    end
    cyc(1'b1, FAST);
    cyc();
    cyc();
    acc_q.delete();
    est_want = 1'b1;
    cyc();
    check("es_speed_pre", speed_level, 5);
    cyc(1'b1, LEFT);
    check("es_speed_zero", speed_level, 0);
    cyc(1'b0, '0, 1'b1, 1'b1, RIGHT);
    repeat (20) cyc(1'b1, FAST);
    check("es_mode", mode_auto, 1'b0);
    check("es_issued", acc_q.size() > 0, 1'b1);
    n = 0;
    foreach (acc_q[i]) if (acc_q[i] != STOP) n++;
    check("es_only_stop", n, 0);
    est_want = 1'b0;
    wait_idle(40);
    cyc(1'b1, FAST);
    wait_idle(40);
    check("es_release", speed_level, 1);
`endif

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
